// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with hold-until-ack imem request and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_HOLD,
    ST_DROP,
    ST_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic        halt_pend;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] drop_pc;

  assign pc_plus4 = pc + 32'd4;
  // Targets are word aligned; the low two bits are dropped.
  assign target   = redirect_pc & ~32'h3;
  // In DROP a redirect only retargets pc; halt outranks it.
  assign drop_pc  = (redirect && !halt) ? target : pc;

  // Request and status outputs decode registered state only.
  assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
  assign imem_addr = req_addr;
  assign halted    = (state == ST_HALT);

  // Fetch FSM, PC, skid buffer and IF/ID register; priority halt > redirect > stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RST;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid_instr <= 32'd0;
      skid_pc4   <= 32'd0;
      halt_pend  <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= 32'd0;
      id_pc4     <= 32'd0;
    end else begin
      case (state)
        ST_RST: begin
          state    <= ST_FETCH;
          req_addr <= pc;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            if (halt) begin
              state    <= ST_HALT;
              id_valid <= 1'b0;
              id_instr <= 32'd0;
            end else if (redirect) begin
              pc       <= target;
              req_addr <= target;
              id_valid <= 1'b0;
              id_instr <= 32'd0;
            end else if (!stall) begin
              id_instr <= imem_rdata;
              id_pc4   <= pc_plus4;
              id_valid <= 1'b1;
              pc       <= pc_plus4;
              req_addr <= pc_plus4;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc4   <= pc_plus4;
              pc         <= pc_plus4;
              state      <= ST_HOLD;
            end
          end else begin
            if (halt) begin
              halt_pend <= 1'b1;
              state     <= ST_DROP;
            end else if (redirect) begin
              // The outstanding request must complete; req_addr stays put.
              pc       <= target;
              id_valid <= 1'b0;
              id_instr <= 32'd0;
              state    <= ST_DROP;
            end else if (!stall) begin
              id_valid <= 1'b0;
              id_instr <= 32'd0;
            end
          end
        end

        ST_HOLD: begin
          if (halt) begin
            state    <= ST_HALT;
            id_valid <= 1'b0;
            id_instr <= 32'd0;
          end else if (redirect) begin
            pc       <= target;
            req_addr <= target;
            id_valid <= 1'b0;
            id_instr <= 32'd0;
            state    <= ST_FETCH;
          end else if (!stall) begin
            id_instr <= skid_instr;
            id_pc4   <= skid_pc4;
            id_valid <= 1'b1;
            req_addr <= pc;
            state    <= ST_FETCH;
          end
        end

        ST_DROP: begin
          if (halt) begin
            halt_pend <= 1'b1;
          end
          pc <= drop_pc;
          if (redirect || !stall) begin
            id_valid <= 1'b0;
            id_instr <= 32'd0;
          end
          if (imem_ack) begin
            // Stale data is thrown away; only the control decision matters.
            if (halt_pend || halt) begin
              state <= ST_HALT;
            end else begin
              req_addr <= drop_pc;
              state    <= ST_FETCH;
            end
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  // memory model state
  int          mem_waits = 0;
  bit          mem_rand  = 1'b0;
  bit          pending   = 1'b0;
  int          cnt       = 0;
  logic [31:0] held_addr = 32'd0;

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory answers with data equal to the address after a configurable wait.
  task automatic step();
    if (imem_req) begin
      if (!pending) begin
        pending   = 1'b1;
        cnt       = mem_rand ? int'($urandom_range(0, 2)) : mem_waits;
        held_addr = imem_addr;
      end else begin
        chk("addr_stable", imem_addr, held_addr);
      end
      if (cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr;
        pending    = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        cnt--;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      pending    = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},    imem_req, 1'b0);
    chk({tag, "_valid"},  id_valid, 1'b0);
    chk({tag, "_instr"},  id_instr, 32'd0);
    chk({tag, "_pc4"},    id_pc4,   32'd0);
    chk({tag, "_halted"}, halted,   1'b0);
  endtask

  logic        p_stall, p_red, p_valid;
  logic [31:0] p_tgt, p_instr, p_pc4, exp_pc;
  int          fresh;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    step(); step();
    chk_reset("reset");

    // zero-wait streaming
    rst_n = 1'b1;
    step();
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h3000);
    chk("first_valid", id_valid, 1'b0);
    step();
    chk("s1_valid", id_valid, 1'b1);
    chk("s1_instr", id_instr, 32'h3000);
    chk("s1_pc4", id_pc4, 32'h3004);
    chk("s1_addr", imem_addr, 32'h3004);
    step();
    chk("s2_valid", id_valid, 1'b1);
    chk("s2_instr", id_instr, 32'h3004);
    chk("s2_addr", imem_addr, 32'h3008);

    // stall three cycles while 3008 is acked
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req", imem_req, 1'b0);
      chk("stall_valid", id_valid, 1'b1);
      chk("stall_instr", id_instr, 32'h3004);
      chk("stall_pc4", id_pc4, 32'h3008);
    end
    stall = 1'b0;
    step();
    chk("skid_valid", id_valid, 1'b1);
    chk("skid_instr", id_instr, 32'h3008);
    chk("skid_pc4", id_pc4, 32'h300C);
    chk("skid_next_addr", imem_addr, 32'h300C);
    step();
    chk("after_skid_instr", id_instr, 32'h300C);

    // two-wait memory, redirect during the first wait cycle of 3010
    mem_waits = 2;
    redirect = 1'b1; redirect_pc = 32'h4000;
    step();
    redirect = 1'b0;
    chk("drop_valid0", id_valid, 1'b0);
    chk("drop_addr0", imem_addr, 32'h3010);
    chk("drop_req0", imem_req, 1'b1);
    step();
    chk("drop_valid1", id_valid, 1'b0);
    chk("drop_addr1", imem_addr, 32'h3010);
    step();
    chk("drop_valid2", id_valid, 1'b0);
    chk("tgt_addr", imem_addr, 32'h4000);
    chk("tgt_req", imem_req, 1'b1);
    step();
    chk("tgt_wait_valid", id_valid, 1'b0);
    step();
    chk("tgt_wait_valid", id_valid, 1'b0);
    step();
    chk("tgt_valid", id_valid, 1'b1);
    chk("tgt_instr", id_instr, 32'h4000);
    chk("tgt_pc4", id_pc4, 32'h4004);

    // redirect together with stall while in HOLD
    mem_waits = 0;
    stall = 1'b1;
    step();
    chk("hold_req", imem_req, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h5000;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("hold_redir_valid", id_valid, 1'b0);
    chk("hold_redir_addr", imem_addr, 32'h5000);
    chk("hold_redir_req", imem_req, 1'b1);
    step();
    chk("hold_redir_instr", id_instr, 32'h5000);
    chk("hold_redir_vld", id_valid, 1'b1);

    // wrap-around with an unaligned target
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_valid", id_valid, 1'b0);
    step();
    chk("wrap_instr", id_instr, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc4, 32'h0000_0000);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);
    step();
    chk("wrap2_instr", id_instr, 32'h0000_0000);
    chk("wrap2_pc4", id_pc4, 32'h0000_0004);

    // halt with a request outstanding
    mem_waits = 2;
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_pend_req", imem_req, 1'b1);
    chk("halt_pend_halted", halted, 1'b0);
    step();
    step();
    chk("halted", halted, 1'b1);
    chk("halted_req", imem_req, 1'b0);
    chk("halted_valid", id_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_sticky_req", imem_req, 1'b0);
      chk("halt_sticky", halted, 1'b1);
    end
    rst_n = 1'b0;
    step();
    chk_reset("rereset");

    // randomized run against a program-order model
    mem_rand = 1'b1;
    rst_n = 1'b1;
    step();
    p_stall = 1'b0; p_red = 1'b0; p_tgt = 32'd0;
    exp_pc = 32'h3000; fresh = 0;
    for (int i = 0; i < 2000; i++) begin
      if (p_red) begin
        chk("rnd_redir_valid", id_valid, 1'b0);
        exp_pc = {p_tgt[31:2], 2'b00};
      end else if (!p_stall) begin
        if (id_valid) begin
          chk("rnd_instr", id_instr, exp_pc);
          chk("rnd_pc4", id_pc4, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          fresh++;
        end
      end else begin
        chk("rnd_hold_valid", id_valid, p_valid);
        chk("rnd_hold_instr", id_instr, p_instr);
        chk("rnd_hold_pc4", id_pc4, p_pc4);
      end
      p_valid = id_valid; p_instr = id_instr; p_pc4 = id_pc4;
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      p_stall = stall; p_red = redirect; p_tgt = redirect_pc;
      step();
    end
    chk("rnd_progress", (fresh >= 200) ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
